// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds all selected domains, then releases them one by one
// in ascending order; a synchronised soft request re-runs the sequence on a channel subset.
module reset_sequencer #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGGER_CYCLES  = 4,
  parameter int unsigned REQ_SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_req,
  input  logic [NUM_CH-1:0] soft_mask,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done,
  output logic [7:0]        seq_cnt
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_CH-1:0]          act_q, act_d;
  logic [NUM_CH-1:0]          pmask_q, pmask_d;
  logic [NUM_CH-1:0]          rst_out_d;
  logic [NUM_CH-1:0]          launch_c;
  logic                       pend_q, pend_d;
  logic                       soft_seq_q, soft_seq_d;
  logic [7:0]                 seq_cnt_d;
  logic                       done_d;
  logic [REQ_SYNC_STAGES-1:0] sync_q;
  logic                       edge_q;
  logic                       pulse_c;
  logic                       req_c;

  // Flops reset to 1 so a request held high through reset is not seen as an edge
  assign pulse_c = sync_q[REQ_SYNC_STAGES-1] & ~edge_q;
  assign req_c   = pulse_c && (soft_mask != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_q      <= '1;
      pmask_q    <= '0;
      pend_q     <= 1'b0;
      soft_seq_q <= 1'b0;
      rst_out    <= '1;
      seq_cnt    <= '0;
      sync_q     <= '1;
      edge_q     <= 1'b1;
      done       <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      pmask_q    <= pmask_d;
      pend_q     <= pend_d;
      soft_seq_q <= soft_seq_d;
      rst_out    <= rst_out_d;
      seq_cnt    <= seq_cnt_d;
      sync_q     <= {sync_q[REQ_SYNC_STAGES-2:0], soft_req};
      edge_q     <= sync_q[REQ_SYNC_STAGES-1];
      done       <= done_d;
      busy       <= ~done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    act_d      = act_q;
    pmask_d    = pmask_q;
    pend_d     = pend_q;
    soft_seq_d = soft_seq_q;
    rst_out_d  = rst_out;
    seq_cnt_d  = seq_cnt;
    launch_c   = '0;

    case (state_q)
      ST_ASSERT: begin
        rst_out_d = act_q;
        if (req_c) begin
          pend_d  = 1'b1;
          pmask_d = pmask_q | soft_mask;
        end
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (req_c) begin
          pend_d  = 1'b1;
          pmask_d = pmask_q | soft_mask;
        end
        // Every channel takes a full stagger slot, masked or not
        if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
          rst_out_d[idx_q] = 1'b0;
          cnt_d            = '0;
          if (idx_q == IDX_W'(NUM_CH - 1)) begin
            state_d = ST_RUN;
            if (soft_seq_q && (seq_cnt != 8'hFF)) begin
              seq_cnt_d = seq_cnt + 8'd1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        rst_out_d = '0;
        launch_c  = (pend_q ? pmask_q : '0) | (req_c ? soft_mask : '0);
        if (launch_c != '0) begin
          state_d    = ST_ASSERT;
          act_d      = launch_c;
          rst_out_d  = launch_c;
          cnt_d      = '0;
          idx_d      = '0;
          pend_d     = 1'b0;
          pmask_d    = '0;
          soft_seq_d = 1'b1;
        end
      end

      default: begin
        state_d   = ST_ASSERT;
        act_d     = '1;
        rst_out_d = '1;
        cnt_d     = '0;
        idx_d     = '0;
      end
    endcase

    done_d = (state_d == ST_RUN);
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: POR table plus hand-written soft-request sequences.
module tb_reset_sequencer;

  localparam int unsigned NCH   = 4;
  localparam int          HOLD  = 16;
  localparam int          STG   = 4;
  localparam int          RUN_C = HOLD + NCH * STG;
  localparam int          POR_N = 43;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           soft_req = 1'b0;
  logic [NCH-1:0] soft_mask = '0;
  logic [NCH-1:0] rst_out;
  logic           busy;
  logic           done;
  logic [7:0]     seq_cnt;

  reset_sequencer #(
    .NUM_CH(NCH), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STG), .REQ_SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .soft_req(soft_req), .soft_mask(soft_mask),
    .rst_out(rst_out), .busy(busy), .done(done), .seq_cnt(seq_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic [NCH-1:0] exp_out;
    logic           exp_done;
    logic [7:0]     exp_seq;
  } vec_t;

  typedef struct {
    logic [NCH-1:0] out;
    logic           done;
    logic [7:0]     seq;
    string          tag;
    int             idx;
  } exp_t;

  vec_t  por_tbl [POR_N];
  exp_t  exp_q [$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    step_no  = 0;
  string tag      = "init";

  // Expected rst_out c cycles after a sequence's first ASSERT cycle (c<0: before it started)
  function automatic logic [NCH-1:0] seq_out(input int c, input logic [NCH-1:0] m);
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = m[k] && (c >= 0) && (c < HOLD + (k + 1) * STG);
    return r;
  endfunction

  function automatic logic seq_done(input int c);
    return (c < 0) || (c >= RUN_C);
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show after the next edge
  task automatic step(input logic r, input logic q, input logic [NCH-1:0] m,
                      input logic [NCH-1:0] eo, input logic ed, input logic [7:0] es);
    exp_t e;
    @(negedge clk);
    rst = r; soft_req = q; soft_mask = m;
    e.out = eo; e.done = ed; e.seq = es; e.tag = tag; e.idx = step_no;
    exp_q.push_back(e);
    step_no++;
  endtask

  task automatic apply_por(input logic q, input logic [NCH-1:0] m);
    for (int i = 0; i < POR_N; i++)
      step(por_tbl[i].rst, q, m, por_tbl[i].exp_out, por_tbl[i].exp_done, por_tbl[i].exp_seq);
  endtask

  // Bounded wait for done; reports a timeout if it never rises
  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (done === 1'b1)
      n_pass++;
    else
      $display("FAIL %s: done not seen within %0d cycles (done=%b busy=%b rst_out=%b)",
               tag, limit, done, busy, rst_out);
  endtask

  always @(posedge clk) begin
    exp_t e;
    logic r_s;
    r_s = rst;
    #1;
    if (r_s === 1'b1) begin
      n_checks++;
      if (rst_out === '1 && done === 1'b0 && busy === 1'b1 && seq_cnt === 8'd0)
        n_pass++;
      else
        $display("FAIL %s reset state: rst_out=%b done=%b busy=%b seq_cnt=%0d, required rst_out=%b done=0 busy=1 seq_cnt=0",
                 tag, rst_out, done, busy, seq_cnt, {NCH{1'b1}});
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (rst_out === e.out && done === e.done && busy === ~e.done && seq_cnt === e.seq)
        n_pass++;
      else
        $display("FAIL %s step %0d: rst_out=%b done=%b busy=%b seq_cnt=%0d, required rst_out=%b done=%b busy=%b seq_cnt=%0d",
                 e.tag, e.idx, rst_out, done, busy, seq_cnt, e.out, e.done, ~e.done, e.seq);
    end
  end

  initial begin
    int c;
    int c2;
    logic [NCH-1:0] eo;
    logic ed;
    logic [7:0] es;

    // POR table: 3 reset cycles, then 40 cycles; step s shows cycle s+1 after rst falls
    for (int i = 0; i < POR_N; i++) begin
      por_tbl[i].rst     = (i < 3);
      por_tbl[i].exp_seq = 8'd0;
      if (i < 3) begin
        por_tbl[i].exp_out  = '1;
        por_tbl[i].exp_done = 1'b0;
      end else begin
        por_tbl[i].exp_out  = seq_out(i - 3 + 1, '1);
        por_tbl[i].exp_done = (i - 3 + 1 >= RUN_C);
      end
    end

    tag = "por";
    apply_por(1'b0, '0);

    tag = "soft_0101";
    for (int j = 0; j <= 40; j++) begin
      c = j - 2;
      step(1'b0, j < 4, 4'b0101, seq_out(c, 4'b0101), seq_done(c), (c >= RUN_C) ? 8'd1 : 8'd0);
    end

    tag = "soft_mask0";
    for (int j = 0; j < 8; j++) step(1'b0, j < 4, 4'b0000, 4'b0000, 1'b1, 8'd1);

    tag = "pending";
    for (int j = 0; j <= 70; j++) begin
      c  = j - 2;
      c2 = c - (RUN_C + 1);
      if (c2 < 0) begin
        eo = seq_out(c, 4'b0001);
        ed = seq_done(c);
      end else begin
        eo = seq_out(c2, 4'b0010);
        ed = (c2 >= RUN_C);
      end
      es = 8'd1 + ((c >= RUN_C) ? 8'd1 : 8'd0) + ((c2 >= RUN_C) ? 8'd1 : 8'd0);
      step(1'b0, (j < 4) || (j >= 22 && j < 27), (j < 11) ? 4'b0001 : 4'b0010, eo, ed, es);
    end

    tag = "rst_mid";
    for (int j = 0; j < 12; j++) begin
      c = j - 2;
      step(1'b0, (j < 4) || (j >= 6), (j < 6) ? 4'b0100 : 4'b1000, seq_out(c, 4'b0100), seq_done(c), 8'd3);
    end
    tag = "rst_mid_por";
    apply_por(1'b0, '0);

    tag = "req_held";
    step(1'b0, 1'b1, 4'b1010, 4'b0000, 1'b1, 8'd0);
    apply_por(1'b1, 4'b1010);
    for (int j = 0; j < 10; j++) step(1'b0, 1'b1, 4'b1010, 4'b0000, 1'b1, 8'd0);
    for (int j = 0; j < 3; j++)  step(1'b0, 1'b0, 4'b1010, 4'b0000, 1'b1, 8'd0);

    tag = "req_toggle";
    for (int j = 0; j <= 36; j++) begin
      c = j - 2;
      step(1'b0, 1'b1, 4'b1010, seq_out(c, 4'b1010), seq_done(c), (c >= RUN_C) ? 8'd1 : 8'd0);
    end

    @(posedge clk);
    #2;
    tag = "final_wait";
    wait_done(RUN_C + 8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
